ah_snoop_fifo_credit: RTL and testbench

- Parametrised successor to the 8-bit/16-entry snoopable FIFO.
- Credit-flow FIFO of DEPTH entries x DATA_W bits, with a content-addressable snoop port that reports whether any occupied entry matches, and how many.
- Sits between a credited producer and a credited consumer in AH fabric datapaths, e.g. a request queue that must be searched for hazards before new traffic is issued.

---
 rtl/ah_snoop_fifo_credit.sv | 147 ++++++++++++++
 tb/tb_ah_snoop_fifo_credit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ah_snoop_fifo_credit.sv
// Credit-flow FIFO with a content-addressable snoop port (match flag + hit count).
// Optional AH_SNOOP_FIFO_MASK_EN adds a snoop_mask input for don't-care bits in the compare.
module ah_snoop_fifo_credit #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int RD_CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_valid,
    output logic                       wr_credit,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       rd_credit,
    input  logic [DATA_W-1:0]          snoop_data,
`ifdef AH_SNOOP_FIFO_MASK_EN
    input  logic [DATA_W-1:0]          snoop_mask,
`endif
    input  logic                       snoop_valid,
    output logic                       snoop_match,
    output logic [$clog2(DEPTH):0]     snoop_hit_cnt,
    output logic                       snoop_done,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       err_overflow,
    output logic                       err_credit
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(RD_CREDITS) + 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     credit_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              snoop_done_reg;
    logic              snoop_match_reg;
    logic [PW-1:0]     snoop_cnt_reg;
    logic              err_overflow_reg;
    logic              err_credit_reg;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              credit_at_max;
    logic [PW-1:0]     occ;
    logic [DEPTH-1:0]  entry_hit;
    logic [PW-1:0]     hit_cnt_next;

    assign full          = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                           (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty         = (wr_ptr_reg == rd_ptr_reg);
    assign push          = wr_valid && !full;
    assign pop           = !empty && (credit_reg != '0);
    assign credit_at_max = (credit_reg == CW'(RD_CREDITS));
    assign occ           = wr_ptr_reg - rd_ptr_reg;

    // Each slot decides for itself whether it is occupied (its distance from
    // rd_ptr is below the occupancy) and whether it matches the key.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] offset;
            logic          occupied;
            logic          key_eq;

            assign offset   = AW'(gi) - rd_ptr_reg[AW-1:0];
            assign occupied = ({1'b0, offset} < occ);
`ifdef AH_SNOOP_FIFO_MASK_EN
            assign key_eq   = (((mem_reg[gi] ^ snoop_data) & snoop_mask) == '0);
`else
            assign key_eq   = (mem_reg[gi] == snoop_data);
`endif
            assign entry_hit[gi] = occupied && key_eq;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        hit_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_cnt_next = hit_cnt_next + PW'(entry_hit[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            credit_reg       <= CW'(RD_CREDITS);
            rd_data_reg      <= '0;
            rd_valid_reg     <= 1'b0;
            snoop_done_reg   <= 1'b0;
            snoop_match_reg  <= 1'b0;
            snoop_cnt_reg    <= '0;
            err_overflow_reg <= 1'b0;
            err_credit_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= pop;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end else if (wr_valid) begin
                err_overflow_reg <= 1'b1;
            end
            if (pop) begin
                rd_data_reg <= mem_reg[rd_ptr_reg[AW-1:0]];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end

            // A simultaneous return and pop cancel out; a return at the
            // ceiling saturates and is flagged.
            if (rd_credit && credit_at_max) begin
                err_credit_reg <= 1'b1;
            end
            if (rd_credit && !pop && !credit_at_max) begin
                credit_reg <= credit_reg + 1'b1;
            end else if (pop && !rd_credit) begin
                credit_reg <= credit_reg - 1'b1;
            end

            snoop_done_reg  <= snoop_valid;
            snoop_match_reg <= snoop_valid && (hit_cnt_next != '0);
            snoop_cnt_reg   <= snoop_valid ? hit_cnt_next : '0;
        end
    end

    assign rd_data       = rd_data_reg;
    assign rd_valid      = rd_valid_reg;
    assign wr_credit     = rd_valid_reg;
    assign snoop_done    = snoop_done_reg;
    assign snoop_match   = snoop_match_reg;
    assign snoop_hit_cnt = snoop_cnt_reg;
    assign occupancy     = occ;
    assign err_overflow  = err_overflow_reg;
    assign err_credit    = err_credit_reg;

endmodule

// File: tb/tb_ah_snoop_fifo_credit.sv
// Self-checking bench for ah_snoop_fifo_credit: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_ah_snoop_fifo_credit;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int RD_CREDITS = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_credit;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_credit;
    logic [DATA_W-1:0] snoop_data;
    logic [DATA_W-1:0] snoop_mask;
    logic              snoop_valid;
    logic              snoop_match;
    logic [4:0]        snoop_hit_cnt;
    logic              snoop_done;
    logic [4:0]        occupancy;
    logic              err_overflow;
    logic              err_credit;

    ah_snoop_fifo_credit #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .RD_CREDITS (RD_CREDITS)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_credit     (wr_credit),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_credit     (rd_credit),
        .snoop_data    (snoop_data),
`ifdef AH_SNOOP_FIFO_MASK_EN
        .snoop_mask    (snoop_mask),
`endif
        .snoop_valid   (snoop_valid),
        .snoop_match   (snoop_match),
        .snoop_hit_cnt (snoop_hit_cnt),
        .snoop_done    (snoop_done),
        .occupancy     (occupancy),
        .err_overflow  (err_overflow),
        .err_credit    (err_credit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];
    int                m_cred;
    bit                m_ovf;
    bit                m_cerr;
    bit                m_rv;
    logic [DATA_W-1:0] m_rd;
    bit                m_sd;
    int                m_scnt;

    // Bench bookkeeping
    int                rv_count;
    int                wc_count;
    bit                last_rv;
    logic [DATA_W-1:0] popped[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cred = RD_CREDITS;
        m_ovf  = 0;
        m_cerr = 0;
        m_rv   = 0;
        m_rd   = '0;
        m_sd   = 0;
        m_scnt = 0;
    endtask

    task automatic model_step(input bit wv, input logic [DATA_W-1:0] wd, input bit rc,
                              input bit sv, input logic [DATA_W-1:0] sd,
                              input logic [DATA_W-1:0] sm);
        int occ = mq.size();
        bit do_pop = (occ > 0) && (m_cred > 0);
        int cnt = 0;
        foreach (mq[i]) if (((mq[i] ^ sd) & sm) == '0) cnt++;
        m_sd   = sv;
        m_scnt = sv ? cnt : 0;
        m_rv   = do_pop;
        if (do_pop) m_rd = mq.pop_front();
        if (wv) begin
            if (occ < DEPTH) mq.push_back(wd);
            else m_ovf = 1;
        end
        if (rc && m_cred == RD_CREDITS) m_cerr = 1;
        if (rc && !do_pop && m_cred < RD_CREDITS) m_cred++;
        else if (do_pop && !rc) m_cred--;
    endtask

    task automatic compare_all();
        check("occupancy", occupancy, mq.size());
        check("rd_valid", rd_valid, m_rv);
        check("wr_credit", wr_credit, m_rv);
        if (m_rv) check("rd_data", rd_data, m_rd);
        check("snoop_done", snoop_done, m_sd);
        check("snoop_match", snoop_match, m_scnt != 0);
        check("snoop_hit_cnt", snoop_hit_cnt, m_scnt);
        check("err_overflow", err_overflow, m_ovf);
        check("err_credit", err_credit, m_cerr);
    endtask

    // One clock of stimulus: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input bit wv, input logic [DATA_W-1:0] wd, input bit rc,
                         input bit sv, input logic [DATA_W-1:0] sd);
        logic [DATA_W-1:0] sm;
`ifdef AH_SNOOP_FIFO_MASK_EN
        sm = snoop_mask;
`else
        sm = '1;
`endif
        wr_valid    = wv;
        wr_data     = wd;
        rd_credit   = rc;
        snoop_valid = sv;
        snoop_data  = sd;
        @(posedge clk);
        model_step(wv, wd, rc, sv, sd, sm);
        @(negedge clk);
        compare_all();
        if (rd_valid) begin
            rv_count++;
            popped.push_back(rd_data);
            $display("[TB] pop data=%02h occ=%0d", rd_data, occupancy);
        end
        if (wr_credit) wc_count++;
        last_rv = rd_valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_wr_credit"}, wr_credit, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_snoop_done"}, snoop_done, 0);
        check({tag, "_snoop_match"}, snoop_match, 0);
        check({tag, "_snoop_cnt"}, snoop_hit_cnt, 0);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_err_ovf"}, err_overflow, 0);
        check({tag, "_err_credit"}, err_credit, 0);
    endtask

    // Called at a negedge; reset is asserted asynchronously between edges.
    task automatic do_reset(input string tag);
        wr_valid    = 0;
        rd_credit   = 0;
        snoop_valid = 0;
        #2 rstn = 0;
        #1 check_zero_outputs(tag);
        model_reset();
        @(negedge clk);
        rstn     = 1;
        last_rv  = 0;
        rv_count = 0;
        wc_count = 0;
        popped.delete();
    endtask

    initial begin
        int owed;
        int occ_ref;
        int occ_changes;
        rstn        = 0;
        wr_valid    = 0;
        wr_data     = '0;
        rd_credit   = 0;
        snoop_valid = 0;
        snoop_data  = '0;
        snoop_mask  = '1;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("reset");

        // Latency: push in N, data out in N+2
        cycle(1, 8'hA5, 0, 0, '0);
        check("lat_no_early_valid", rd_valid, 0);
        cycle(0, '0, 0, 0, '0);
        check("lat_rd_valid", rd_valid, 1);
        check("lat_rd_data", rd_data, 8'hA5);
        check("lat_wr_credit", wr_credit, 1);

        // Credit stall: only RD_CREDITS pops without returns, then one per return
        do_reset("stall_reset");
        for (int i = 0; i < 8; i++) cycle(1, DATA_W'(8'h40 + i), 0, 0, '0);
        idle(6);
        check("stall_pops", rv_count, RD_CREDITS);
        cycle(0, '0, 1, 0, '0);
        cycle(0, '0, 0, 0, '0);
        check("stall_credit_pop", rd_valid, 1);
        idle(4);
        check("stall_pops_after_credit", rv_count, RD_CREDITS + 1);

        // Fill to full, overflow, then drain in order
        do_reset("fill_reset");
        for (int i = 0; i < 20; i++) cycle(1, DATA_W'(i), 0, 0, '0);
        check("fill_occupancy", occupancy, DEPTH);
        cycle(1, 8'hEE, 0, 0, '0);
        check("fill_overflow_flag", err_overflow, 1);
        check("fill_occ_after_ovf", occupancy, DEPTH);
        popped.delete();
        rv_count = 0;
        wc_count = 0;
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0, '0);
        idle(3);
        check("drain_pops", rv_count, DEPTH);
        check("drain_wr_credits", wc_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) check("drain_order", popped[i], 4 + i);
        check("drain_no_credit_err", err_credit, 0);

        // Snoop: only occupied entries count
        do_reset("snoop_reset");
        for (int i = 0; i < RD_CREDITS; i++) cycle(1, 8'h00, 0, 0, '0);
        cycle(1, 8'h11, 0, 0, '0);
        cycle(1, 8'h22, 0, 0, '0);
        cycle(1, 8'h11, 0, 0, '0);
        idle(1);
        cycle(0, '0, 1, 0, '0);
        idle(1);
        cycle(0, '0, 0, 1, 8'h11);
        check("snoop11_done", snoop_done, 1);
        check("snoop11_match", snoop_match, 1);
        check("snoop11_cnt", snoop_hit_cnt, 1);
        cycle(0, '0, 0, 1, 8'h33);
        check("snoop33_done", snoop_done, 1);
        check("snoop33_match", snoop_match, 0);
        check("snoop33_cnt", snoop_hit_cnt, 0);
        cycle(0, '0, 1, 0, '0);
        cycle(0, '0, 1, 0, '0);
        idle(3);
        check("snoop_drained", occupancy, 0);
        cycle(0, '0, 0, 1, 8'h22);
        check("snoop_empty_done", snoop_done, 1);
        check("snoop_empty_match", snoop_match, 0);
        check("snoop_empty_cnt", snoop_hit_cnt, 0);

        // Wrap: push every cycle, consumer echoes each rd_valid as a credit
        do_reset("wrap_reset");
        occ_changes = 0;
        occ_ref = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(1, DATA_W'($urandom), last_rv, 0, '0);
            if (occ_ref < 0) occ_ref = occupancy;
            else if (occupancy != occ_ref) occ_changes++;
        end
        check("wrap_occ_constant", occ_changes, 0);
        check("wrap_pops", rv_count, 39);
        check("wrap_err_ovf", err_overflow, 0);
        check("wrap_err_credit", err_credit, 0);

        // Random traffic against the model
        do_reset("rand_reset");
        owed = 0;
        for (int i = 0; i < 600; i++) begin
            bit rc;
            owed += last_rv ? 1 : 0;
            rc = (owed > 0) && ($urandom_range(0, 1) == 1);
            if (rc) owed--;
`ifdef AH_SNOOP_FIFO_MASK_EN
            snoop_mask = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
`endif
            cycle($urandom_range(0, 2) != 0, DATA_W'($urandom_range(0, 7)), rc,
                  $urandom_range(0, 1) == 1, DATA_W'($urandom_range(0, 7)));
        end
        snoop_mask = '1;

        // Credit overflow, then reset mid-stream
        do_reset("cerr_reset");
        cycle(0, '0, 1, 0, '0);
        check("credit_overflow_flag", err_credit, 1);
        cycle(1, 8'h01, 0, 1, 8'h01);
        cycle(1, 8'h02, 0, 1, 8'h02);
        cycle(1, 8'h03, 0, 1, 8'h01);
        do_reset("midreset");
        for (int i = 0; i < 6; i++) cycle(1, DATA_W'(8'h70 + i), 0, 0, '0);
        idle(4);
        check("credits_restored", rv_count, RD_CREDITS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
